obi_mem_xbar: RTL

- Parametrised N-master to M-slave crossbar for the core-side req/gnt/rvalid memory protocol. It replaces point-to-point wiring of the core instruction and data ports.
- Sits between RISC-V core ports, debug/DMA masters and on-chip memories/peripherals.
- Address decode comes from a runtime start/end map, with round-robin arbitration per slave.
- Provides in-order response routing through per-slave outstanding FIFOs and an internal decode-error responder.

---
 rtl/obi_mem_xbar.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/obi_mem_xbar.sv
// obi_mem_xbar: N-master to M-slave req/gnt/rvalid crossbar with
// runtime address map, per-slave round-robin and decode-error target.
module obi_mem_xbar #(
  parameter int N_MASTER        = 2,
  parameter int N_SLAVE         = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [N_MASTER-1:0]            m_req_i,
  output logic [N_MASTER-1:0]            m_gnt_o,
  input  logic [N_MASTER*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [N_MASTER-1:0]            m_we_i,
  input  logic [N_MASTER*DATA_WIDTH/8-1:0] m_be_i,
  input  logic [N_MASTER*DATA_WIDTH-1:0] m_wdata_i,
  output logic [N_MASTER-1:0]            m_rvalid_o,
  output logic [N_MASTER*DATA_WIDTH-1:0] m_rdata_o,
  output logic [N_MASTER-1:0]            m_err_o,
  output logic [N_SLAVE-1:0]             s_req_o,
  input  logic [N_SLAVE-1:0]             s_gnt_i,
  output logic [N_SLAVE*ADDR_WIDTH-1:0]  s_addr_o,
  output logic [N_SLAVE-1:0]             s_we_o,
  output logic [N_SLAVE*DATA_WIDTH/8-1:0] s_be_o,
  output logic [N_SLAVE*DATA_WIDTH-1:0]  s_wdata_o,
  input  logic [N_SLAVE-1:0]             s_rvalid_i,
  input  logic [N_SLAVE*DATA_WIDTH-1:0]  s_rdata_i,
  input  logic [N_SLAVE-1:0]             s_err_i,
  input  logic [N_SLAVE*ADDR_WIDTH-1:0]  start_addr_i,
  input  logic [N_SLAVE*ADDR_WIDTH-1:0]  end_addr_i
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam int NT   = N_SLAVE + 1;
  localparam int MW   = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
  localparam int TW   = $clog2(N_SLAVE + 1);
  localparam int CW   = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] MAX_C  = CW'(MAX_OUTSTANDING);
  localparam logic [TW-1:0] ERR_T  = TW'(N_SLAVE);
  localparam logic [MW-1:0] LAST_M = MW'(N_MASTER - 1);
  localparam logic [PW-1:0] LAST_P = PW'(MAX_OUTSTANDING - 1);

  logic [CW-1:0] r_cnt  [N_MASTER];
  logic [TW-1:0] r_tgt  [N_MASTER];
  logic [MW-1:0] r_rr   [NT];
  logic [N_SLAVE-1:0] r_lock;
  logic [MW-1:0] r_lock_m [N_SLAVE];
  logic [MW-1:0] r_fifo [N_SLAVE][MAX_OUTSTANDING];
  logic [PW-1:0] r_wp   [N_SLAVE];
  logic [PW-1:0] r_rp   [N_SLAVE];
  logic [CW-1:0] r_fc   [N_SLAVE];
  logic          r_e_v;
  logic [MW-1:0] r_e_m;

  logic [TW-1:0]       w_dec  [N_MASTER];
  logic [NT-1:0]       w_open;
  logic [N_MASTER-1:0] w_elig [NT];
  logic [NT-1:0]       w_win_v;
  logic [MW-1:0]       w_win  [NT];
  logic [NT-1:0]       w_hs;
  logic [N_MASTER-1:0] w_gnt;
  logic [N_SLAVE-1:0]  w_pop;
  logic [MW-1:0]       w_head [N_SLAVE];
  logic [N_MASTER-1:0] w_rsp;

  // Lowest-indexed matching region wins, so scan downwards
  always_comb begin
    for (int m = 0; m < N_MASTER; m++) begin
      w_dec[m] = ERR_T;
      for (int k = N_SLAVE - 1; k >= 0; k--) begin
        if (m_addr_i[m*ADDR_WIDTH +: ADDR_WIDTH] >= start_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH] &&
            m_addr_i[m*ADDR_WIDTH +: ADDR_WIDTH] <= end_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH])
          w_dec[m] = TW'(k);
      end
    end
  end

  always_comb begin
    w_open = '1;
    for (int k = 0; k < N_SLAVE; k++) w_open[k] = (r_fc[k] != MAX_C);
    for (int t = 0; t < NT; t++) begin
      for (int m = 0; m < N_MASTER; m++) begin
        w_elig[t][m] = m_req_i[m] && (r_cnt[m] < MAX_C) &&
                       (r_cnt[m] == '0 || r_tgt[m] == TW'(t)) &&
                       (w_dec[m] == TW'(t)) && w_open[t];
      end
    end
  end

  always_comb begin
    w_win_v = '0;
    w_hs    = '0;
    w_gnt   = '0;
    for (int t = 0; t < NT; t++) begin
      w_win[t] = '0;
      for (int i = 0; i < N_MASTER; i++) begin
        if (!w_win_v[t] && w_elig[t][(int'(r_rr[t]) + i) % N_MASTER]) begin
          w_win_v[t] = 1'b1;
          w_win[t]   = MW'((int'(r_rr[t]) + i) % N_MASTER);
        end
      end
    end
    // A stalled request keeps its master until the slave grants it
    for (int k = 0; k < N_SLAVE; k++) begin
      if (r_lock[k]) begin
        w_win_v[k] = 1'b1;
        w_win[k]   = r_lock_m[k];
      end
      w_hs[k] = w_win_v[k] && s_gnt_i[k];
    end
    w_hs[N_SLAVE] = w_win_v[N_SLAVE];
    for (int t = 0; t < NT; t++) begin
      if (w_hs[t]) w_gnt[w_win[t]] = 1'b1;
    end
  end

  always_comb begin
    w_rsp = '0;
    w_pop = '0;
    for (int k = 0; k < N_SLAVE; k++) begin
      w_head[k] = r_fifo[k][r_rp[k]];
      w_pop[k]  = s_rvalid_i[k] && (r_fc[k] != '0);
      if (w_pop[k]) w_rsp[w_head[k]] = 1'b1;
    end
    if (r_e_v) w_rsp[r_e_m] = 1'b1;
  end

  always_comb begin
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    m_rdata_o  = '0;
    m_err_o    = '0;
    s_req_o    = '0;
    s_addr_o   = '0;
    s_we_o     = '0;
    s_be_o     = '0;
    s_wdata_o  = '0;
    if (rst_ni) begin
      m_gnt_o    = w_gnt;
      m_rvalid_o = w_rsp;
      for (int k = 0; k < N_SLAVE; k++) begin
        s_req_o[k] = w_win_v[k];
        if (w_win_v[k]) begin
          s_addr_o[k*ADDR_WIDTH +: ADDR_WIDTH] =
            m_addr_i[int'(w_win[k])*ADDR_WIDTH +: ADDR_WIDTH];
          s_we_o[k] = m_we_i[w_win[k]];
          s_be_o[k*BE_W +: BE_W] = m_be_i[int'(w_win[k])*BE_W +: BE_W];
          s_wdata_o[k*DATA_WIDTH +: DATA_WIDTH] =
            m_wdata_i[int'(w_win[k])*DATA_WIDTH +: DATA_WIDTH];
        end
        if (w_pop[k]) begin
          m_rdata_o[int'(w_head[k])*DATA_WIDTH +: DATA_WIDTH] =
            s_rdata_i[k*DATA_WIDTH +: DATA_WIDTH];
          m_err_o[w_head[k]] = s_err_i[k];
        end
      end
      if (r_e_v) m_err_o[r_e_m] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int m = 0; m < N_MASTER; m++) begin
        r_cnt[m] <= '0;
        r_tgt[m] <= '0;
      end
      for (int t = 0; t < NT; t++) r_rr[t] <= '0;
      for (int k = 0; k < N_SLAVE; k++) begin
        r_lock_m[k] <= '0;
        r_wp[k]     <= '0;
        r_rp[k]     <= '0;
        r_fc[k]     <= '0;
      end
      r_lock <= '0;
      r_e_v  <= 1'b0;
      r_e_m  <= '0;
    end else begin
      for (int m = 0; m < N_MASTER; m++) begin
        r_cnt[m] <= r_cnt[m] + CW'(w_gnt[m]) - CW'(w_rsp[m]);
        if (w_gnt[m]) r_tgt[m] <= w_dec[m];
      end
      for (int t = 0; t < NT; t++) begin
        if (w_hs[t]) r_rr[t] <= (w_win[t] == LAST_M) ? '0 : w_win[t] + 1'b1;
      end
      for (int k = 0; k < N_SLAVE; k++) begin
        if (w_hs[k]) begin
          r_lock[k] <= 1'b0;
          r_fifo[k][r_wp[k]] <= w_win[k];
          r_wp[k] <= (r_wp[k] == LAST_P) ? '0 : r_wp[k] + 1'b1;
        end else if (w_win_v[k]) begin
          r_lock[k]   <= 1'b1;
          r_lock_m[k] <= w_win[k];
        end
        if (w_pop[k]) r_rp[k] <= (r_rp[k] == LAST_P) ? '0 : r_rp[k] + 1'b1;
        r_fc[k] <= r_fc[k] + CW'(w_hs[k]) - CW'(w_pop[k]);
      end
      r_e_v <= w_hs[N_SLAVE];
      r_e_m <= w_win[N_SLAVE];
    end
  end

endmodule
